// File: rtl/reaction_counter.sv
// Reaction-game timing datapath: randomized countdown to "go", then a BCD
// millisecond reaction counter with a saturating count of 1000 ms rollovers.
module reaction_counter #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DELAY_MIN_MS = 1000,
  parameter bit          LFSR_EN      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] enable,
  output logic       flag,
  output logic       go_led,
  output logic [3:0] one,
  output logic [3:0] ten,
  output logic [3:0] hun,
  output logic [9:0] overflow
);

  localparam int unsigned PS_W  = $clog2(TICK_DIV);
  localparam int unsigned DLY_W = $clog2(DELAY_MIN_MS + 1024);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_COUNT = 2'b01,
    PH_REACT = 2'b10,
    PH_SEG7  = 2'b11
  } phase_t;

  phase_t              phase;
  phase_t              enable_q;
  logic [PS_W-1:0]     prescaler;
  logic [DLY_W-1:0]    delay;
  logic [9:0]          lfsr;
  logic                entry;
  logic                tick;
  logic                saturated;

  always_comb begin
    phase     = phase_t'(enable);
    entry     = (phase != enable_q);
    tick      = (prescaler == PS_W'(TICK_DIV - 1));
    saturated = (overflow == 10'd1023) && (hun == 4'd9) &&
                (ten == 4'd9) && (one == 4'd9);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_q  <= PH_IDLE;
      flag      <= 1'b0;
      go_led    <= 1'b0;
      one       <= '0;
      ten       <= '0;
      hun       <= '0;
      overflow  <= '0;
      prescaler <= '0;
      delay     <= '0;
      lfsr      <= 10'h2A5;
    end else begin
      enable_q <= phase;
      go_led   <= (phase == PH_REACT);
      // x^10 + x^7 + 1; the all-zero state is unreachable from the seed
      lfsr     <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};

      case (phase)
        PH_COUNT: begin
          if (entry) begin
            prescaler <= '0;
            delay     <= DLY_W'(DELAY_MIN_MS) + (LFSR_EN ? DLY_W'(lfsr) : '0);
            flag      <= 1'b0;
          end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick && (delay != '0)) begin
              delay <= delay - DLY_W'(1);
              if (delay == DLY_W'(1))
                flag <= 1'b1;
            end
          end
        end

        PH_REACT: begin
          flag <= 1'b0;
          if (entry) begin
            prescaler <= '0;
            one       <= '0;
            ten       <= '0;
            hun       <= '0;
            overflow  <= '0;
          end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick && !saturated) begin
              if (one != 4'd9) begin
                one <= one + 4'd1;
              end else begin
                one <= '0;
                if (ten != 4'd9) begin
                  ten <= ten + 4'd1;
                end else begin
                  ten <= '0;
                  if (hun != 4'd9) begin
                    hun <= hun + 4'd1;
                  end else begin
                    hun      <= '0;
                    overflow <= overflow + 10'd1;
                  end
                end
              end
            end
          end
        end

        default: begin
          flag      <= 1'b0;
          prescaler <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_counter.sv
// Bench for reaction_counter: two parameterisations share one stimulus stream
// and are checked every cycle against a millisecond-level reference model.
`timescale 1ns/1ps
module tb_reaction_counter;

  localparam int MS_MAX = 1023 * 1000 + 999;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en;

  logic       a_flag, a_go, b_flag, b_go;
  logic [3:0] a_one, a_ten, a_hun, b_one, b_ten, b_hun;
  logic [9:0] a_ovf, b_ovf;

  int tests = 0;
  int fails = 0;

  // reference model state: index 0 = dut_a, 1 = dut_b
  int m_td[2]   = '{4, 2};
  int m_dmin[2] = '{2, 1};
  int m_len[2]  = '{0, 1};
  int m_lfsr, m_prev, m_go;
  int m_pc[2], m_rem[2], m_flag[2], m_ms[2];

  int n, v;
  int vs[3];
  int ds[3];

  always #5 clk = ~clk;

  reaction_counter #(.TICK_DIV(4), .DELAY_MIN_MS(2), .LFSR_EN(1'b0)) dut_a (
    .clock(clk), .reset(rst), .enable(en), .flag(a_flag), .go_led(a_go),
    .one(a_one), .ten(a_ten), .hun(a_hun), .overflow(a_ovf));

  reaction_counter #(.TICK_DIV(2), .DELAY_MIN_MS(1), .LFSR_EN(1'b1)) dut_b (
    .clock(clk), .reset(rst), .enable(en), .flag(b_flag), .go_led(b_go),
    .one(b_one), .ten(b_ten), .hun(b_hun), .overflow(b_ovf));

  function automatic int lfsr_adv(input int x);
    return ((x << 1) & 'h3FF) | (((x >> 9) ^ (x >> 6)) & 1);
  endfunction

  task automatic model_step();
    bit entry, tick;
    if (rst) begin
      m_prev = 0; m_go = 0; m_lfsr = 'h2A5;
      for (int i = 0; i < 2; i++) begin
        m_pc[i] = 0; m_rem[i] = 0; m_flag[i] = 0; m_ms[i] = 0;
      end
    end else begin
      entry = (int'(en) != m_prev);
      for (int i = 0; i < 2; i++) begin
        tick = 1'b0;
        if (en == 2'd1 || en == 2'd2) begin
          if (entry) m_pc[i] = 0;
          else begin
            m_pc[i]++;
            if (m_pc[i] == m_td[i]) begin m_pc[i] = 0; tick = 1'b1; end
          end
        end else m_pc[i] = 0;
        if (en == 2'd1) begin
          if (entry) begin
            m_rem[i] = m_dmin[i] + (m_len[i] != 0 ? m_lfsr : 0);
            m_flag[i] = 0;
          end else if (tick && m_rem[i] > 0) begin
            m_rem[i]--;
            if (m_rem[i] == 0) m_flag[i] = 1;
          end
        end else m_flag[i] = 0;
        if (en == 2'd2) begin
          if (entry) m_ms[i] = 0;
          else if (tick && m_ms[i] < MS_MAX) m_ms[i]++;
        end
      end
      m_go = (en == 2'd2) ? 1 : 0;
      m_lfsr = lfsr_adv(m_lfsr);
      m_prev = int'(en);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic f, input logic g,
                          input logic [3:0] o, input logic [3:0] t,
                          input logic [3:0] h, input logic [9:0] ov);
    string p;
    p = (i == 0) ? "a" : "b";
    chk({p, "_flag"},     32'(f),  32'(m_flag[i]));
    chk({p, "_go_led"},   32'(g),  32'(m_go));
    chk({p, "_one"},      32'(o),  32'(m_ms[i] % 10));
    chk({p, "_ten"},      32'(t),  32'((m_ms[i] / 10) % 10));
    chk({p, "_hun"},      32'(h),  32'((m_ms[i] / 100) % 10));
    chk({p, "_overflow"}, 32'(ov), 32'(m_ms[i] / 1000));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk_inst(0, a_flag, a_go, a_one, a_ten, a_hun, a_ovf);
    chk_inst(1, b_flag, b_go, b_one, b_ten, b_hun, b_ovf);
  endtask

  task automatic wait_flag_b(input int start, output int cnt);
    cnt = start;
    while (b_flag !== 1'b1 && cnt < 2200) begin
      cycle();
      cnt++;
    end
  endtask

  task automatic chk_digits(input string tag, input logic [9:0] ov, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] o, input int exp_ms);
    chk({tag, "_ovf"}, 32'(ov), 32'(exp_ms / 1000));
    chk({tag, "_hun"}, 32'(h),  32'((exp_ms / 100) % 10));
    chk({tag, "_ten"}, 32'(t),  32'((exp_ms / 10) % 10));
    chk({tag, "_one"}, 32'(o),  32'(exp_ms % 10));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 2'd0;
    repeat (2) cycle();
    chk_digits("reset_a", a_ovf, a_hun, a_ten, a_one, 0);
    chk("reset_b_flag", 32'(b_flag), 0);

    // countdown straight out of reset: dut_b delay is 1 + 10'h2A5 = 678 ms
    rst = 1'b0; en = 2'd1;
    for (int k = 0; k <= 8; k++) begin
      cycle();
      chk("cd_flag_a", 32'(a_flag), (k == 8) ? 32'd1 : 32'd0);
    end
    wait_flag_b(8, n);
    chk("cd_seed_delay_b", 32'(n), 32'd1356);
    repeat (5) cycle();
    chk("cd_flag_hold_a", 32'(a_flag), 32'd1);

    en = 2'd2;
    cycle();
    chk("cd_flag_drop_a", 32'(a_flag), 32'd0);
    chk("cd_flag_drop_b", 32'(b_flag), 32'd0);
    chk("go_led_a", 32'(a_go), 32'd1);

    // reaction: entry edge R already taken, tick R+548 still in reaction
    repeat (548) cycle();
    chk_digits("react_a", a_ovf, a_hun, a_ten, a_one, 137);
    chk_digits("react_b", b_ovf, b_hun, b_ten, b_one, 274);
    en = 2'd3;
    repeat (100) cycle();
    chk_digits("seg7_hold_a", a_ovf, a_hun, a_ten, a_one, 137);
    en = 2'd0;
    repeat (100) cycle();
    chk_digits("idle_hold_a", a_ovf, a_hun, a_ten, a_one, 137);
    chk_digits("idle_hold_b", b_ovf, b_hun, b_ten, b_one, 274);
    chk("go_led_idle_a", 32'(a_go), 32'd0);

    // rollover
    en = 2'd2;
    cycle();
    repeat (4690) cycle();
    chk_digits("roll_b", b_ovf, b_hun, b_ten, b_one, 2345);
    chk_digits("roll_a", a_ovf, a_hun, a_ten, a_one, 1172);

    // saturation: jump dut_b to the top of the range and keep ticking
    force dut_b.overflow = 10'd1023;
    force dut_b.hun = 4'd9;
    force dut_b.ten = 4'd9;
    force dut_b.one = 4'd9;
    #1;
    release dut_b.overflow;
    release dut_b.hun;
    release dut_b.ten;
    release dut_b.one;
    m_ms[1] = MS_MAX;
    repeat (21) cycle();
    chk_digits("sat_b", b_ovf, b_hun, b_ten, b_one, MS_MAX);

    // reset mid-reaction at 0/4/2
    en = 2'd0; cycle();
    en = 2'd2; cycle();
    repeat (168) cycle();
    chk_digits("pre_rst_a", a_ovf, a_hun, a_ten, a_one, 42);
    rst = 1'b1;
    repeat (2) cycle();
    chk_digits("mid_rst_a", a_ovf, a_hun, a_ten, a_one, 0);
    chk_digits("mid_rst_b", b_ovf, b_hun, b_ten, b_one, 0);
    chk("mid_rst_go_a", 32'(a_go), 32'd0);
    rst = 1'b0; en = 2'd1;
    cycle();
    wait_flag_b(0, n);
    chk("lfsr_restart_delay_b", 32'(n), 32'd1356);

    // randomized LFSR delays, each entry at a distinct LFSR value
    for (int r = 0; r < 3; r++) begin
      en = 2'd0;
      repeat ($urandom_range(1, 50)) cycle();
      while ((r > 0 && m_lfsr == vs[0]) || (r > 1 && m_lfsr == vs[1])) cycle();
      vs[r] = m_lfsr;
      en = 2'd1;
      cycle();
      wait_flag_b(0, n);
      ds[r] = n;
      chk("lfsr_delay_b", 32'(n), 32'(2 * (1 + vs[r])));
    end
    chk("lfsr_delays_differ", 32'((ds[0] != ds[1]) && (ds[1] != ds[2]) && (ds[0] != ds[2])), 32'd1);

    // abort 3 cycles before dut_a expiry, then re-enter
    en = 2'd0; cycle();
    en = 2'd1; cycle();
    repeat (4) cycle();
    en = 2'd0;
    repeat (6) cycle();
    chk("abort_flag_a", 32'(a_flag), 32'd0);
    v = m_lfsr;
    en = 2'd1;
    cycle();
    wait_flag_b(0, n);
    chk("abort_relatch_b", 32'(n), 32'(2 * (1 + v)));
    chk("abort_reentry_flag_a", 32'(a_flag), 32'd1);

    // random phase walk with occasional reset
    for (int r = 0; r < 30; r++) begin
      rst = ($urandom_range(0, 9) == 0);
      en = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) cycle();
    end
    rst = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reaction_counter.md
# reaction_counter

Timing datapath for the reaction-time game. Consumes the 2-bit `enable` phase code from the game state machine, generates the randomized pre-"go" delay and raises `flag` when it expires, then counts reaction time in milliseconds as BCD digits plus an overflow count. These feed the 7-segment display and the high-score tracker. It is the responder end of the `enable`/`flag` interface driven by the game controller.

## Interface

- `TICK_DIV`, 50000: clock cycles per millisecond tick (50 MHz clock); must be ≥ 2
- `DELAY_MIN_MS`, 1000: fixed part of the countdown delay in ms; must be ≥ 1
- `LFSR_EN`, 1: 1 adds the LFSR value (0..1023 ms) to the delay; 0 adds 0
- `clock` in 1: system clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `enable` in 2: phase code; 00 idle, 01 countdown, 10 reaction, 11 seg7
- `flag` out 1: countdown expired; stays high while in countdown
- `go_led` out 1: high while `enable` == 10
- `one` out 4: BCD ms units
- `ten` out 4: BCD ms tens
- `hun` out 4: BCD ms hundreds
- `overflow` out 10: binary count of completed 1000 ms rollovers, saturating at 1023

## Operation

- `enable_q` register holds the previous `enable`. An entry to phase P is `enable` == P and `enable_q` != P.
- LFSR: 10-bit Fibonacci, x^10+x^7+1, seed 10'h2A5. Advances every clock in every phase and never reaches 0.
- Prescaler: 0..TICK_DIV-1. Advances only in countdown and reaction. `tick` = (prescaler == TICK_DIV-1), and the prescaler wraps to 0 on tick. It is cleared to 0 on entry to countdown or reaction, and held at 0 in idle and seg7.
- On countdown entry:
  - `delay` ← DELAY_MIN_MS + (LFSR_EN ? lfsr : 0). Width is sufficient for DELAY_MIN_MS+1023.
  - `flag` ← 0.
- In countdown:
  - On each tick with `delay` > 0, decrement `delay`.
  - On the tick that takes `delay` from 1 to 0, set `flag` ← 1.
  - `flag` then holds 1 until `enable` leaves 01. Any other phase forces `flag` to 0.
- On reaction entry, clear `one`, `ten`, `hun` and `overflow` to 0.
- In reaction, each tick increments the BCD count:
  - `one` 9→0 carries into `ten`.
  - `ten` 9→0 carries into `hun`.
  - `hun` 9→0 increments `overflow`.
- Saturation: when `overflow` == 1023 and the digits are 9/9/9, further ticks are ignored and the count holds.
- Idle and seg7: digits and `overflow` hold their last values, so the result remains visible and the high-score block samples it in idle.
- A phase change mid-count abandons the count with no residual effect. Re-entering countdown relatches `delay` from the current LFSR.

## Timing

- Reset: `flag`=0, `go_led`=0, `one`=`ten`=`hun`=0, `overflow`=0, prescaler=0, `delay`=0, `enable_q`=00, lfsr=10'h2A5. Reset overrides `enable` in the same cycle.
- `go_led` is registered and follows `enable` with 1 cycle of latency.
- Let the entry edge E be the first rising edge at which the new `enable` is sampled.
  - The first tick is sampled at edge E+TICK_DIV.
  - `flag` rises at edge E + delay×TICK_DIV.
- In reaction, after entry edge R the count equals N ms immediately after edge R + N×TICK_DIV.
- Simultaneous events:
  - A tick coinciding with the edge where `enable` changes phase is ignored; the entry action wins.
  - A tick on the same edge as `reset` is ignored.

## Test plan

- Reset: assert `reset` for 2 cycles mid-reaction with count 0/4/2 → all outputs are 0 the next cycle, and the LFSR restarts at 10'h2A5.
- Countdown (TICK_DIV=4, DELAY_MIN_MS=2, LFSR_EN=0): drive `enable` 00→01 at edge E → `flag` is 0 through E+7, rises at E+8, and holds until `enable`=10, then drops the next cycle.
- Reaction count (TICK_DIV=4): `enable`=10 from edge R for 4×137 cycles, then `enable`=11 → `hun`/`ten`/`one`=1/3/7, `overflow`=0. The values hold unchanged for 100 cycles in seg7 and in subsequent idle.
- Rollover (TICK_DIV=2): 2×2345 cycles in reaction → `overflow`=2, `hun`/`ten`/`one`=3/4/5. Separately, force 1023/9/9/9 and run 10 more ticks → the value is unchanged.
- LFSR delay (TICK_DIV=2, DELAY_MIN_MS=1, LFSR_EN=1): enter countdown and compare against the reference LFSR model value v → `flag` rises exactly 2×(1+v) cycles after entry. Repeat 3 times and check the delays differ.
- Abort: leave countdown (01→00) 3 cycles before expiry, then re-enter → `flag` stays 0 throughout the abort, and the new delay is relatched from the current LFSR.
